uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller placed directly behind the UART receiver unit (BaudGenR/SIPO/DeFrame/ErrorCheck chain).
- Detects each completed frame, classifies it by error flags and buffers good frames in a small FIFO with a valid/ready consumer interface.
- Keeps saturating per-type error counters.
- Owns the receiver's baud_rate/parity_type configuration and applies host changes only between frames, so a frame is never received with mixed settings.

Parameters:
FIFO_DEPTH, 4, frame buffer entries; power of two, >= 2
CNT_W, 8, width of each error counter
DROP_ERR, 1, 1 = frames with any error bit set are counted but not buffered; 0 = buffered with their error bits
RST_BAUD, 2'b00, baud_rate value after reset
RST_PARITY, 2'b00, parity_type value after reset

Ports:
clock  in  1  system clock, same clock that drives the receiver
reset_n  in  1  reset; synchronous, active-low
rx_done  in  1  receiver done_flag
rx_active  in  1  receiver active_flag (frame in progress)
rx_error  in  3  receiver error_flag: [0] parity, [1] start, [2] stop
rx_data  in  8  receiver data_out
cfg_wr  in  1  one-cycle strobe: request new configuration
cfg_baud  in  2  requested baud_rate, sampled on cfg_wr
cfg_parity  in  2  requested parity_type, sampled on cfg_wr
cfg_busy  out  1  request pending, not yet applied
baud_rate  out  2  registered, drives receiver baud_rate
parity_type  out  2  registered, drives receiver parity_type
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head when m_valid & m_ready
m_data  out  8  FIFO head data; 0 when empty
m_err  out  3  FIFO head error bits; 0 when empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overrun  out  1  sticky: a frame was lost because FIFO was full
err_clr  in  1  one-cycle strobe: clear counters and overrun
par_err_cnt  out  CNT_W  parity error count
start_err_cnt  out  CNT_W  start error count
stop_err_cnt  out  CNT_W  stop error count

Behaviour:
- Reset, sampled at a clock edge with reset_n=0, overrides everything, including mid-frame or mid-config:
  - outputs: baud_rate=RST_BAUD, parity_type=RST_PARITY, cfg_busy=0, m_valid=0, m_data=0, m_err=0, fifo_count=0, overrun=0, all counters 0.
  - internal: FIFO emptied, pending config discarded, done_q=0.
- Frame capture:
  - done_q <= rx_done every cycle; capture event cap = rx_done & ~done_q.
  - A level held high for several cycles gives exactly one capture.
  - On cap, rx_data and rx_error are sampled in that same cycle.
- Buffering:
  - push = cap & ~(DROP_ERR & |rx_error).
  - pop = m_valid & m_ready.
  - A push into an empty FIFO shows m_valid=1 and the head on the next cycle (1-cycle latency).
  - Full and push without pop: frame dropped, overrun <= 1, count unchanged.
  - Full and push with pop in the same cycle: both happen, count stays FIFO_DEPTH, no overrun.
  - Empty and pop: impossible, since m_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count = pushes - pops, in range 0..FIFO_DEPTH.
- Error counters:
  - On cap, each counter whose rx_error bit is 1 increments by 1.
  - Counters saturate at 2^CNT_W-1.
  - Counters count every captured frame, whether or not it is pushed or dropped.
  - err_clr zeroes all counters and overrun; err_clr wins over a same-cycle increment or overrun set.
- Config FSM, states IDLE, PEND, APPLY:
  - IDLE: cfg_wr latches cfg_baud/cfg_parity into shadow -> PEND; cfg_busy=1 from the next cycle.
  - PEND: a new cfg_wr overwrites the shadow (last write wins). Move to APPLY in the first cycle with rx_active=0 and rx_done=0.
  - APPLY (1 cycle): baud_rate/parity_type <= shadow -> IDLE; cfg_busy=0 from the following cycle.
  - A cfg_wr during APPLY re-latches the shadow and goes to PEND instead of IDLE.
  - Minimum request-to-output latency with the receiver idle is 2 cycles after the cfg_wr cycle.
- All outputs are registered.

Test Plan:
- Reset, then one clean frame (rx_data=8'hA5, rx_error=0, rx_done high 3 cycles) -> one push; m_valid=1 one cycle after the rising edge; m_data=8'hA5, fifo_count=1; m_ready=1 -> m_valid=0, fifo_count=0.
- Five clean frames 8'h01..8'h05 with m_ready=0, FIFO_DEPTH=4 -> fifo_count=4, overrun=1; draining yields 01,02,03,04. Then repeat with m_ready=1 on the 5th rise while full -> no overrun, 05 is the last out.
- Frame with rx_error=3'b101, DROP_ERR=1 -> par_err_cnt=1, stop_err_cnt=1, start_err_cnt=0, fifo_count unchanged. Same frame with DROP_ERR=0 -> m_err=3'b101.
- 260 frames with rx_error=3'b010, CNT_W=8 -> start_err_cnt=255. Then err_clr in the same cycle as another error capture -> all counters 0, overrun 0.
- cfg_wr (baud 2'b11, parity 2'b01) while rx_active=1 -> cfg_busy=1 and baud_rate unchanged until rx_active and rx_done are both 0; applied 1 cycle later, cfg_busy=0 the next cycle. A second cfg_wr (2'b10) while pending -> 2'b10 is applied.
- reset_n=0 for one cycle with FIFO holding 3 entries, config pending and counters nonzero -> every output equals its reset value on the next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame buffer, error statistics and between-frame configuration for a UART receiver
// Ports: clock/reset_n (sync, active-low); rx_* from the receiver; cfg_wr/cfg_baud/cfg_parity host
// request with cfg_busy; baud_rate/parity_type drive the receiver; m_valid/m_ready/m_data/m_err
// consumer handshake; fifo_count/overrun buffer status; err_clr and *_err_cnt error statistics.
module uart_rx_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 8,
    parameter bit         DROP_ERR   = 1'b1,
    parameter logic [1:0] RST_BAUD   = 2'b00,
    parameter logic [1:0] RST_PARITY = 2'b00
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rx_done,
    input  logic                        rx_active,
    input  logic [2:0]                  rx_error,
    input  logic [7:0]                  rx_data,
    input  logic                        cfg_wr,
    input  logic [1:0]                  cfg_baud,
    input  logic [1:0]                  cfg_parity,
    output logic                        cfg_busy,
    output logic [1:0]                  baud_rate,
    output logic [1:0]                  parity_type,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [7:0]                  m_data,
    output logic [2:0]                  m_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        err_clr,
    output logic [CNT_W-1:0]            par_err_cnt,
    output logic [CNT_W-1:0]            start_err_cnt,
    output logic [CNT_W-1:0]            stop_err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PEND, APPLY} cfg_state_e;

    logic             done_q;
    logic [10:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [10:0]      head_q, head_d;
    logic             valid_q, overrun_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic             cap, push, pop, full, wr_en, drop;
    cfg_state_e       state_q, state_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [1:0]       baud_q, baud_d, parity_q, parity_d;
    logic             busy_q, busy_d;

    assign cap      = rx_done & ~done_q;
    assign push     = cap & ~(DROP_ERR & (|rx_error));
    assign pop      = valid_q & m_ready;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign wr_en    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign count_d  = count_q + CW'(wr_en) - CW'(pop);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    // When nothing older survives this cycle's pop, the frame being written becomes the new head.
    assign head_d   = (count_d == '0) ? '0
                    : (count_q == CW'(pop)) ? {rx_error, rx_data} : mem_q[rd_ptr_d];

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= {rx_error, rx_data};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= rx_done;
            wr_ptr_q  <= wr_ptr_q + AW'(wr_en);
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            valid_q   <= count_d != '0;
            overrun_q <= err_clr ? 1'b0 : (overrun_q | drop);
        end
    end

    // Error counters: index 0 parity, 1 start, 2 stop; saturate at all-ones.
    always_ff @(posedge clock) begin
        if (!reset_n || err_clr) begin
            cnt_q <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++)
                if (cap && rx_error[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            baud_q   <= RST_BAUD;
            parity_q <= RST_PARITY;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            baud_q   <= baud_d;
            parity_q <= parity_d;
            busy_q   <= busy_d;
        end
    end

    // A pending request is only applied once the receiver is neither mid-frame nor reporting done.
    always_comb begin
        state_d  = state_q;
        shadow_d = cfg_wr ? {cfg_baud, cfg_parity} : shadow_q;
        baud_d   = baud_q;
        parity_d = parity_q;
        case (state_q)
            IDLE:    state_d = cfg_wr ? PEND : IDLE;
            PEND:    state_d = (!rx_active && !rx_done) ? APPLY : PEND;
            APPLY: begin
                baud_d   = shadow_q[3:2];
                parity_d = shadow_q[1:0];
                state_d  = cfg_wr ? PEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    assign cfg_busy      = busy_q;
    assign baud_rate     = baud_q;
    assign parity_type   = parity_q;
    assign m_valid       = valid_q;
    assign m_data        = head_q[7:0];
    assign m_err         = head_q[10:8];
    assign fifo_count    = count_q;
    assign overrun       = overrun_q;
    assign par_err_cnt   = cnt_q[0];
    assign start_err_cnt = cnt_q[1];
    assign stop_err_cnt  = cnt_q[2];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl, one instance dropping error frames and one keeping them
module tb_uart_rx_ctrl;
    localparam int D = 4;
    localparam int SAT = 255;

    logic clock = 1'b0, reset_n = 1'b0, rx_done = 1'b0, rx_active = 1'b0;
    logic cfg_wr = 1'b0, m_ready = 1'b0, err_clr = 1'b0;
    logic [2:0] rx_error = '0;
    logic [7:0] rx_data = '0;
    logic [1:0] cfg_baud = '0, cfg_parity = '0;

    logic [1:0]       busy, mval, ovr;
    logic [1:0][1:0]  baud, par;
    logic [1:0][7:0]  mdata, pcnt, scnt, tcnt;
    logic [1:0][2:0]  merr, cnt;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0, rdy_rand = 1'b0;

    // Reference model state: occupancy per instance, sticky overrun, counters, expected frame queues.
    int occ [2];
    bit ov [2];
    int cnt_m [3];
    bit prev_done;
    logic [10:0] exp0 [$];
    logic [10:0] exp1 [$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_rx_ctrl #(.FIFO_DEPTH(D), .CNT_W(8), .DROP_ERR(g == 0), .RST_BAUD(2'b00), .RST_PARITY(2'b00)) u_dut (
            .clock(clock), .reset_n(reset_n), .rx_done(rx_done), .rx_active(rx_active),
            .rx_error(rx_error), .rx_data(rx_data), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
            .cfg_parity(cfg_parity), .cfg_busy(busy[g]), .baud_rate(baud[g]), .parity_type(par[g]),
            .m_valid(mval[g]), .m_ready(m_ready), .m_data(mdata[g]), .m_err(merr[g]),
            .fifo_count(cnt[g]), .overrun(ovr[g]), .err_clr(err_clr),
            .par_err_cnt(pcnt[g]), .start_err_cnt(scnt[g]), .stop_err_cnt(tcnt[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] e, input int hold, input int gap);
        rx_data = d;
        rx_error = e;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        repeat (n) tick();
        m_ready = 1'b0;
    endtask

    // Model: checks status outputs against its state, then advances by what the coming edge samples.
    always @(negedge clock) begin
        bit cap, pop, push;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("fifo_count%0d", k), int'(cnt[k]), occ[k]);
                chk($sformatf("m_valid%0d", k), int'(mval[k]), int'(occ[k] != 0));
                chk($sformatf("overrun%0d", k), int'(ovr[k]), int'(ov[k]));
                if (occ[k] == 0) begin
                    chk($sformatf("m_data_empty%0d", k), int'(mdata[k]), 0);
                    chk($sformatf("m_err_empty%0d", k), int'(merr[k]), 0);
                end
                chk($sformatf("par_cnt%0d", k), int'(pcnt[k]), cnt_m[0]);
                chk($sformatf("start_cnt%0d", k), int'(scnt[k]), cnt_m[1]);
                chk($sformatf("stop_cnt%0d", k), int'(tcnt[k]), cnt_m[2]);
            end
        end
        if (!reset_n) begin
            occ = '{0, 0};
            ov = '{0, 0};
            cnt_m = '{0, 0, 0};
            prev_done = 1'b0;
            exp0.delete();
            exp1.delete();
        end else begin
            cap = rx_done && !prev_done;
            for (int i = 0; i < 3; i++)
                if (cap && rx_error[i] && cnt_m[i] < SAT) cnt_m[i]++;
            for (int k = 0; k < 2; k++) begin
                pop = occ[k] > 0 && m_ready;
                push = cap && !(k == 0 && rx_error != 0);
                if (push && (occ[k] < D || pop)) begin
                    if (k == 0) exp0.push_back({rx_error, rx_data});
                    else exp1.push_back({rx_error, rx_data});
                    occ[k]++;
                end else if (push) begin
                    ov[k] = 1'b1;
                end
                if (pop) occ[k]--;
            end
            if (err_clr) begin
                cnt_m = '{0, 0, 0};
                ov = '{0, 0};
            end
            prev_done = rx_done;
        end
    end

    // Monitor: on every accepted head, compare against the oldest expected frame.
    always @(negedge clock) begin
        logic [10:0] e;
        int sz;
        if (chk_en && reset_n && m_ready) begin
            for (int k = 0; k < 2; k++) begin
                if (mval[k]) begin
                    sz = (k == 0) ? exp0.size() : exp1.size();
                    chk($sformatf("scoreboard_nonempty%0d", k), int'(sz > 0), 1);
                    if (sz > 0) begin
                        if (k == 0) e = exp0.pop_front();
                        else e = exp1.pop_front();
                        chk($sformatf("m_data%0d", k), int'(mdata[k]), int'(e[7:0]));
                        chk($sformatf("m_err%0d", k), int'(merr[k]), int'(e[10:8]));
                    end
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset_baud", int'(baud[0]), 0);
        chk("reset_parity", int'(par[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);

        // Single clean frame with a 3-cycle done level.
        send(8'hA5, 3'b000, 3, 1);
        @(negedge clock);
        chk("first_valid", int'(mval[0]), 1);
        chk("first_data", int'(mdata[0]), 8'hA5);
        chk("first_count", int'(cnt[0]), 1);
        drain(1);
        @(negedge clock);
        chk("first_drained", int'(mval[0]), 0);

        // Overflow: fifth frame lost, then full with a same-cycle pop.
        for (int i = 1; i <= 5; i++) send(8'(i), 3'b000, 1, 1);
        @(negedge clock);
        chk("ovf_count", int'(cnt[0]), D);
        chk("ovf_flag", int'(ovr[0]), 1);
        drain(6);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 3'b000, 1, 1);
        rx_data = 8'h05;
        rx_done = 1'b1;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        rx_done = 1'b0;
        tick();
        @(negedge clock);
        chk("full_pop_count", int'(cnt[0]), D);
        chk("full_pop_no_ovr", int'(ovr[0]), 0);
        drain(6);

        // Error frame: dropped by instance 0, kept with its error bits by instance 1.
        send(8'h77, 3'b101, 2, 1);
        @(negedge clock);
        chk("err_par", int'(pcnt[0]), 1);
        chk("err_start", int'(scnt[0]), 0);
        chk("err_stop", int'(tcnt[0]), 1);
        chk("err_dropped", int'(cnt[0]), 0);
        chk("err_kept", int'(cnt[1]), 1);
        chk("err_bits", int'(merr[1]), 3'b101);
        drain(2);

        // Saturation, then clear colliding with a capture.
        for (int i = 0; i < 260; i++) send(8'(i), 3'b010, 1, 1);
        @(negedge clock);
        chk("start_sat", int'(scnt[0]), SAT);
        rx_error = 3'b011;
        rx_done = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clock);
        chk("clr_par", int'(pcnt[0]), 0);
        chk("clr_start", int'(scnt[0]), 0);
        chk("clr_ovr1", int'(ovr[1]), 0);
        tick();
        rx_done = 1'b0;
        tick();
        drain(6);

        // Config with idle receiver: applied 2 cycles after the request cycle.
        cfg_wr = 1'b1;
        cfg_baud = 2'b11;
        cfg_parity = 2'b01;
        tick();
        cfg_wr = 1'b0;
        @(negedge clock);
        chk("cfg_busy_set", int'(busy[0]), 1);
        chk("cfg_not_yet", int'(baud[0]), 0);
        tick();
        @(negedge clock);
        chk("cfg_apply_cycle", int'(baud[0]), 0);
        tick();
        @(negedge clock);
        chk("cfg_baud_idle", int'(baud[0]), 3);
        chk("cfg_parity_idle", int'(par[0]), 1);
        chk("cfg_busy_clr", int'(busy[0]), 0);

        // Config held off by an active receiver and by done; last write wins.
        rx_active = 1'b1;
        cfg_wr = 1'b1;
        cfg_baud = 2'b01;
        cfg_parity = 2'b11;
        tick();
        cfg_wr = 1'b0;
        repeat (4) tick();
        @(negedge clock);
        chk("cfg_held_busy", int'(busy[0]), 1);
        chk("cfg_held_baud", int'(baud[0]), 3);
        cfg_wr = 1'b1;
        cfg_baud = 2'b10;
        cfg_parity = 2'b10;
        tick();
        cfg_wr = 1'b0;
        rx_active = 1'b0;
        rx_data = 8'h3C;
        rx_error = 3'b000;
        rx_done = 1'b1;
        repeat (2) tick();
        @(negedge clock);
        chk("cfg_held_done", int'(baud[0]), 3);
        rx_done = 1'b0;
        tick();
        @(negedge clock);
        chk("cfg_apply_wait", int'(baud[0]), 3);
        tick();
        @(negedge clock);
        chk("cfg_baud_last", int'(baud[0]), 2);
        chk("cfg_parity_last", int'(par[0]), 2);
        chk("cfg_busy_last", int'(busy[0]), 0);
        drain(3);

        // Randomised traffic with a randomly stalling consumer and occasional clears.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            err_clr = ($urandom_range(0, 24) == 0);
            tick();
            err_clr = 1'b0;
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                 $urandom_range(1, 3), $urandom_range(1, 3));
        end
        rdy_rand = 1'b0;
        drain(8);
        @(negedge clock);
        chk("rand_drained0", exp0.size(), 0);
        chk("rand_drained1", exp1.size(), 0);

        // Reset mid-config with buffered frames and nonzero counters.
        for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 3'b000, 1, 1);
        send(8'h99, 3'b001, 1, 1);
        rx_active = 1'b1;
        cfg_wr = 1'b1;
        cfg_baud = 2'b01;
        cfg_parity = 2'b01;
        tick();
        cfg_wr = 1'b0;
        tick();
        @(negedge clock);
        chk("pre_rst_count", int'(cnt[0]), 3);
        chk("pre_rst_busy", int'(busy[0]), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        rx_active = 1'b0;
        @(negedge clock);
        chk("rst_baud", int'(baud[0]), 0);
        chk("rst_parity", int'(par[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), int'(mval[k]), 0);
            chk($sformatf("rst_count%0d", k), int'(cnt[k]), 0);
            chk($sformatf("rst_par%0d", k), int'(pcnt[k]), 0);
        end
        repeat (4) tick();
        @(negedge clock);
        chk("rst_cfg_discarded", int'(baud[0]), 0);
        chk("rst_busy_stays", int'(busy[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
